// File: rtl/matrix_serial_tx.sv
// MAX7219-style 8x8 matrix refresher: snapshots eight row bytes and shifts them out as digit-register writes.
// Define MATRIX_SERIAL_TX_INIT_EN to send a five-frame configuration sequence after every reset.
module matrix_serial_tx #(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       CLOCK_50,
  input  logic       RESET_InHigh,
  input  logic [7:0] row0_in,
  input  logic [7:0] row1_in,
  input  logic [7:0] row2_in,
  input  logic [7:0] row3_in,
  input  logic [7:0] row4_in,
  input  logic [7:0] row5_in,
  input  logic [7:0] row6_in,
  input  logic [7:0] row7_in,
  input  logic       start_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       ser_din_out,
  output logic       ser_clk_out,
  output logic       ser_load_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
`ifdef MATRIX_SERIAL_TX_INIT_EN
    INIT       = 3'd1,
`endif
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    LATCH      = 3'd4,
    NEXT       = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef MATRIX_SERIAL_TX_INIT_EN
  localparam state_t RESET_STATE = INIT;
  localparam logic   RESET_BUSY  = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  state_t      state_reg;
  logic [7:0]  snap_reg [8];
  logic [7:0]  rows [8];
  logic [2:0]  frame_reg;
  logic [3:0]  bit_reg;
  logic [7:0]  div_reg;
  logic        init_mode_reg;
  logic [15:0] cur_word;
  logic [3:0]  next_bit;
  logic [2:0]  last_frame;
  logic        div_end;

  assign rows[0] = row0_in;
  assign rows[1] = row1_in;
  assign rows[2] = row2_in;
  assign rows[3] = row3_in;
  assign rows[4] = row4_in;
  assign rows[5] = row5_in;
  assign rows[6] = row6_in;
  assign rows[7] = row7_in;

  assign next_bit   = bit_reg - 4'd1;
  assign last_frame = init_mode_reg ? 3'd4 : 3'd7;
  assign div_end    = (div_reg == DIV_LAST);

  // Row k is written to digit register k+1; config frames replace it while init runs.
  always_comb begin
    cur_word = {4'h0, {1'b0, frame_reg} + 4'd1, snap_reg[frame_reg]};
    if (init_mode_reg) begin
      case (frame_reg)
        3'd0:    cur_word = 16'h0C01;
        3'd1:    cur_word = 16'h0900;
        3'd2:    cur_word = {12'h0A0, INTENSITY};
        3'd3:    cur_word = 16'h0B07;
        default: cur_word = 16'h0F00;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_reg     <= RESET_STATE;
      busy_out      <= RESET_BUSY;
      init_mode_reg <= RESET_BUSY;
      done_out      <= 1'b0;
      ser_din_out   <= 1'b0;
      ser_clk_out   <= 1'b0;
      ser_load_out  <= 1'b1;
      frame_reg     <= 3'd0;
      bit_reg       <= 4'd0;
      div_reg       <= 8'd0;
      for (int i = 0; i < 8; i++) snap_reg[i] <= 8'h00;
    end else begin
      done_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            for (int i = 0; i < 8; i++) snap_reg[i] <= rows[i];
            frame_reg    <= 3'd0;
            bit_reg      <= 4'd15;
            div_reg      <= 8'd0;
            busy_out     <= 1'b1;
            ser_load_out <= 1'b0;
            ser_clk_out  <= 1'b0;
            // Bit 15 of every frame sits in the zero upper nibble.
            ser_din_out  <= 1'b0;
            state_reg    <= SHIFT_LOW;
          end
        end
`ifdef MATRIX_SERIAL_TX_INIT_EN
        INIT: begin
          frame_reg    <= 3'd0;
          bit_reg      <= 4'd15;
          div_reg      <= 8'd0;
          ser_load_out <= 1'b0;
          ser_clk_out  <= 1'b0;
          ser_din_out  <= 1'b0;
          state_reg    <= SHIFT_LOW;
        end
`endif
        SHIFT_LOW: begin
          if (div_end) begin
            div_reg     <= 8'd0;
            ser_clk_out <= 1'b1;
            state_reg   <= SHIFT_HIGH;
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        SHIFT_HIGH: begin
          if (div_end) begin
            div_reg     <= 8'd0;
            ser_clk_out <= 1'b0;
            if (bit_reg == 4'd0) begin
              ser_load_out <= 1'b1;
              state_reg    <= LATCH;
            end else begin
              bit_reg     <= next_bit;
              ser_din_out <= cur_word[next_bit];
              state_reg   <= SHIFT_LOW;
            end
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        LATCH: begin
          // The NEXT decision is taken on the edge that ends LATCH so it costs no cycle.
          if (div_end) begin
            div_reg <= 8'd0;
            if (frame_reg != last_frame) begin
              frame_reg    <= frame_reg + 3'd1;
              bit_reg      <= 4'd15;
              ser_load_out <= 1'b0;
              ser_din_out  <= 1'b0;
              state_reg    <= SHIFT_LOW;
            end else begin
              frame_reg     <= 3'd0;
              busy_out      <= 1'b0;
              done_out      <= ~init_mode_reg;
              init_mode_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        NEXT: begin
          // Never held as a registered state; fall back to a clean idle line.
          busy_out      <= 1'b0;
          init_mode_reg <= 1'b0;
          ser_load_out  <= 1'b1;
          ser_clk_out   <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          busy_out      <= 1'b0;
          init_mode_reg <= 1'b0;
          ser_load_out  <= 1'b1;
          ser_clk_out   <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_serial_tx.sv
// Bench for matrix_serial_tx: decodes the DIN/CLK/LOAD line into frames and compares them
// against frames built from the row snapshot, plus done/busy cycle timing.
module tb_matrix_serial_tx;

`ifdef MATRIX_SERIAL_TX_INIT_EN
  localparam int CLK_DIV = 1;
`else
  localparam int CLK_DIV = 2;
`endif
  localparam int REFRESH = 264 * CLK_DIV;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] row_v [8];
  logic       busy, done, din, sclk, load;

  int errors = 0;
  int checks = 0;

  matrix_serial_tx #(.CLK_DIV(CLK_DIV), .INTENSITY(4'h8)) dut (
    .CLOCK_50(clk), .RESET_InHigh(srst),
    .row0_in(row_v[0]), .row1_in(row_v[1]), .row2_in(row_v[2]), .row3_in(row_v[3]),
    .row4_in(row_v[4]), .row5_in(row_v[5]), .row6_in(row_v[6]), .row7_in(row_v[7]),
    .start_in(start), .busy_out(busy), .done_out(done),
    .ser_din_out(din), .ser_clk_out(sclk), .ser_load_out(load)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  // Line decoder: what a MAX7219 would latch.
  logic [15:0] shreg = 16'h0000;
  int          nbits = 0;
  int          clk_rises = 0;
  int          stray = 0;
  int          partial_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] cap_q [$];
  logic [15:0] exp_q [$];

  always @(posedge sclk) begin
    clk_rises++;
    if (load === 1'b0) begin
      shreg = {shreg[14:0], din};
      nbits++;
    end else begin
      stray++;
    end
  end

  always @(posedge load) begin
    if (nbits == 16) cap_q.push_back(shreg);
    else if (nbits != 0) partial_cnt++;
    nbits = 0;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic push_expected();
    for (int k = 0; k < 8; k++) exp_q.push_back({4'h0, 4'(k + 1), row_v[k]});
  endtask

  task automatic randomize_rows();
    for (int k = 0; k < 8; k++) row_v[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 200 * CLK_DIV + 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_idle: busy=%b required 0 within budget", busy); end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) row_v[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== (CLK_DIV == 1 ? 1'b1 : 1'b0) && busy !== 1'b0 && busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_x: busy=%b", busy);
    end
`ifdef MATRIX_SERIAL_TX_INIT_EN
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
`else
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
`endif
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", sclk); end
    checks++;
    if (load !== 1'b1) begin errors++; $display("FAIL reset_load: got %b required 1", load); end
    checks++;
    if (din !== 1'b0) begin errors++; $display("FAIL reset_din: got %b required 0", din); end
    $display("test_reset: busy=%b done=%b clk=%b load=%b din=%b", busy, done, sclk, load, din);
  endtask

  task automatic test_idle();
    int r0;
    @(negedge clk);
    srst = 1'b0;
    r0 = clk_rises;
    repeat (100) @(negedge clk);
    checks++;
    if (clk_rises != r0) begin errors++; $display("FAIL idle_clk_edges: got %0d required 0", clk_rises - r0); end
    checks++;
    if (busy !== 1'b0 || load !== 1'b1 || sclk !== 1'b0 || done_cnt != 0) begin
      errors++; $display("FAIL idle_levels: busy=%b load=%b clk=%b dones=%0d required 0/1/0/0", busy, load, sclk, done_cnt);
    end
    $display("test_idle: 100 cycles, clk edges=%0d", clk_rises - r0);
  endtask

  task automatic test_init();
    int e1, n, seen;
    cap_q.delete();
    @(negedge clk);
    srst = 1'b0;
    @(posedge clk);
    #1;
    e1 = edges;
    seen = 0;
    n = 0;
    for (int i = 0; i < 165 * CLK_DIV + 20; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (busy === 1'b0) begin seen = 1; n = edges - e1; break; end
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || n != 165 * CLK_DIV) begin errors++; $display("FAIL init_busy_fall: got %0d required %0d", n, 165 * CLK_DIV); end
    checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL init_after: busy=%b dones=%0d required 0/0", busy, done_cnt); end
    exp_q.delete();
    exp_q.push_back(16'h0C01); exp_q.push_back(16'h0900); exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07); exp_q.push_back(16'h0F00);
    checks++;
    if (cap_q.size() != 5) begin errors++; $display("FAIL init_frame_count: got %0d required 5", cap_q.size()); end
    for (int k = 0; k < 5; k++) begin
      logic [15:0] got;
      got = (k < cap_q.size()) ? cap_q[k] : 16'hxxxx;
      checks++;
      if (got !== exp_q[k]) begin errors++; $display("FAIL init_frame%0d: got %h required %h", k, got, exp_q[k]); end
    end
    $display("test_init: busy fell after %0d cycles, %0d frames", n, cap_q.size());
  endtask

  task automatic test_refresh(input bit disturb, input string name);
    int t, d0, got_cycle, seen;
    logic got_busy;
    cap_q.delete();
    exp_q.delete();
    push_expected();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t = edges;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got %b required 1", name, busy); end
    @(negedge clk);
    start = 1'b0;
    seen = 0; got_cycle = 0; got_busy = 1'bx;
    for (int i = 0; i < REFRESH + 20; i++) begin
      if (i > 0) @(negedge clk);
      if (done === 1'b1) begin seen = 1; got_cycle = edges + 1; got_busy = busy; break; end
      if (disturb) begin
        if (i == 0) begin
          row_v[0] = 8'hFF; row_v[1] = 8'h21; row_v[2] = 8'h21; row_v[3] = 8'h2F;
          row_v[4] = 8'h2F; row_v[5] = 8'hA8; row_v[6] = 8'hA8; row_v[7] = 8'hEF;
        end
        start = (i == 100 || i == 300 || i == 301);
      end
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || got_cycle != t + REFRESH + 1) begin
      errors++; $display("FAIL %s_done_cycle: got %0d required %0d", name, got_cycle, t + REFRESH + 1);
    end
    checks++;
    if (got_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b required 0", name, got_busy); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt - d0); end
    checks++;
    if (cap_q.size() != 8 || stray != 0) begin
      errors++; $display("FAIL %s_frame_count: got %0d stray=%0d required 8/0", name, cap_q.size(), stray);
    end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] got;
      got = (k < cap_q.size()) ? cap_q[k] : 16'hxxxx;
      checks++;
      if (got !== exp_q[k]) begin errors++; $display("FAIL %s_frame%0d: got %h required %h", name, k, got, exp_q[k]); end
    end
    $display("%s: start edge %0d, done cycle %0d, frames %0d, first %h last %h", name, t, got_cycle,
             cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 16'h0, (cap_q.size() > 7) ? cap_q[7] : 16'h0);
  endtask

  task automatic test_back_to_back();
    int t1, c1, c2, d0, seen1, seen2;
    cap_q.delete();
    exp_q.delete();
    randomize_rows();
    push_expected();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t1 = edges;
    seen1 = 0; c1 = 0;
    for (int i = 0; i < REFRESH + 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen1 = 1; c1 = edges + 1; break; end
    end
    randomize_rows();
    push_expected();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b required 1", busy); end
    @(negedge clk);
    start = 1'b0;
    seen2 = 0; c2 = 0;
    for (int i = 0; i < REFRESH + 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen2 = 1; c2 = edges + 1; break; end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (!seen1 || c1 != t1 + REFRESH + 1) begin errors++; $display("FAIL b2b_done1: got %0d required %0d", c1, t1 + REFRESH + 1); end
    checks++;
    if (!seen2 || c2 != c1 + REFRESH + 1) begin errors++; $display("FAIL b2b_done2: got %0d required %0d", c2, c1 + REFRESH + 1); end
    checks++;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d required 2", done_cnt - d0); end
    checks++;
    if (cap_q.size() != 16) begin errors++; $display("FAIL b2b_frame_count: got %0d required 16", cap_q.size()); end
    for (int k = 0; k < 16; k++) begin
      logic [15:0] got;
      got = (k < cap_q.size()) ? cap_q[k] : 16'hxxxx;
      checks++;
      if (got !== exp_q[k]) begin errors++; $display("FAIL b2b_frame%0d: got %h required %h", k, got, exp_q[k]); end
    end
    $display("test_back_to_back: done cycles %0d and %0d, frames %0d", c1, c2, cap_q.size());
  endtask

  task automatic test_reset_mid_frame();
    int found, p0;
    cap_q.delete();
    exp_q.delete();
    randomize_rows();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < REFRESH + 20; i++) begin
      @(negedge clk);
      if (cap_q.size() == 4 && nbits == 7) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach: frame %0d bit count %0d required 4/7", cap_q.size(), nbits); end
    p0 = partial_cnt;
    srst = 1'b1;
    @(posedge clk);
    #1;
`ifdef MATRIX_SERIAL_TX_INIT_EN
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b required 1", busy); end
`else
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
`endif
    checks++;
    if (done !== 1'b0 || din !== 1'b0 || sclk !== 1'b0 || load !== 1'b1) begin
      errors++; $display("FAIL midreset_levels: done=%b din=%b clk=%b load=%b required 0/0/0/1", done, din, sclk, load);
    end
    checks++;
    if (partial_cnt - p0 != 1 || cap_q.size() != 4) begin
      errors++; $display("FAIL midreset_discard: partial=%0d frames=%0d required 1/4", partial_cnt - p0, cap_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      logic [15:0] got;
      got = (k < cap_q.size()) ? cap_q[k] : 16'hxxxx;
      checks++;
      if (got !== exp_q[k]) begin errors++; $display("FAIL midreset_frame%0d: got %h required %h", k, got, exp_q[k]); end
    end
    $display("test_reset_mid_frame: reset after %0d frames, partial frames %0d", cap_q.size(), partial_cnt - p0);
    @(negedge clk);
    srst = 1'b0;
`ifdef MATRIX_SERIAL_TX_INIT_EN
    wait_idle();
`endif
    randomize_rows();
    test_refresh(1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
`ifdef MATRIX_SERIAL_TX_INIT_EN
    test_init();
`else
    test_idle();
`endif
    row_v[0] = 8'hF2; row_v[1] = 8'h26; row_v[2] = 8'h2A; row_v[3] = 8'h22;
    row_v[4] = 8'h22; row_v[5] = 8'hA2; row_v[6] = 8'hA2; row_v[7] = 8'hEF;
    test_refresh(1'b0, "refresh_fixed");
    randomize_rows();
    test_refresh(1'b1, "refresh_disturbed");
    for (int r = 0; r < 2; r++) begin
      randomize_rows();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      test_refresh(1'b0, "refresh_random");
    end
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
